// File: rtl/fir_pkg.sv
// Shared constants for the moving-average filter chain and its output stage.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package fir_pkg;

    // Sample width used by the filter and the output stage.
    localparam int SAMPLE_W       = 16;
    // The filter scales its output by 2^SCALE_SHIFT (128).
    localparam int SCALE_SHIFT    = 7;
    // Width of the saturating dropped-sample counter.
    localparam int DROP_CNT_W     = 8;
    // Default decimation ratio and output FIFO depth.
    localparam int DECIM_DEF      = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    // Round-half-up removal of the filter scale. The sum is one bit wider
    // than the sample so that values near full scale do not wrap.
    function automatic logic [SAMPLE_W-1:0] descale_round(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W:0] sum;
        sum = {1'b0, x} + ((SAMPLE_W+1)'(1) << (SCALE_SHIFT - 1));
        return SAMPLE_W'(sum >> SCALE_SHIFT);
    endfunction

endpackage

// File: rtl/fir_decim_out_if.sv
// Valid/ready stream carrying descaled, decimated samples to the consumer.
// Latency: n/a (wires only).
// Backpressure: consumer holds out_ready low; producer keeps out_data stable.
interface fir_decim_out_if import fir_pkg::*; #(
    parameter int N = SAMPLE_W
);
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sync_fifo.sv
// Generic register-array FIFO with push/pop, full flag and occupancy count.
// Latency: 1 clk from push edge to data visible at the head (no bypass).
// Backpressure: push at full is ignored unless a pop happens on the same edge.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic [AW:0]  count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot the push needs, so full+pop is legal.
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fir_decim_out.sv
// Descales filter output (round-half-up), decimates by DECIM, buffers in a FIFO.
// Latency: 1 clk from the kept sample's edge to out_valid.
// Backpressure: out_ready low fills the FIFO; kept samples arriving at full are dropped and counted.
module fir_decim_out import fir_pkg::*; #(
    parameter int N     = SAMPLE_W,
    parameter int SHIFT = SCALE_SHIFT,
    parameter int DECIM = DECIM_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          filtered_scaled,
    input  logic                  sample_en,
    fir_decim_out_if.master       dout,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count,
    input  logic                  clear_ovf
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N:0]    sum;
    logic [N-1:0]  descaled;
    logic [PW-1:0] phase;
    logic          keep;
    logic          pop;
    logic          drop;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [N-1:0]  fifo_rdata;

    // Round-half-up descale in N+1 bits so full-scale input cannot wrap.
    assign sum      = {1'b0, filtered_scaled} + ((N+1)'(1) << (SHIFT - 1));
    assign descaled = N'(sum >> SHIFT);

    assign keep = sample_en && (phase == '0);
    assign pop  = dout.out_valid && dout.out_ready;
    assign drop = keep && fifo_full && !pop;

    // Decimation phase advances only on enabled samples; with DECIM=1 it stays at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
        end else if (sample_en) begin
            phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_ovf)
                drop_count <= DROP_CNT_W'(1);
            else if (drop_count != '1)
                drop_count <= drop_count + DROP_CNT_W'(1);
        end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    sync_fifo #(
        .W     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (keep),
        .wdata (descaled),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign dout.out_valid = (fifo_count != '0);
    assign dout.out_data  = fifo_rdata;

endmodule

// File: tb/tb_fir_decim_out.sv
// Self-checking bench for fir_decim_out: queue scoreboard plus directed boundary checks.
// Latency: n/a.
// Backpressure: driven directly through out_ready.
module tb_fir_decim_out;
    import fir_pkg::*;

    localparam int N     = SAMPLE_W;
    localparam int DEPTH = 4;
    localparam int DECIM = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0]          filtered_scaled;
    logic                  sample_en;
    logic                  clear_ovf;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_count;

    fir_decim_out_if #(.N(N)) dif ();

    fir_decim_out #(
        .N     (N),
        .SHIFT (SCALE_SHIFT),
        .DECIM (DECIM),
        .DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .filtered_scaled (filtered_scaled),
        .sample_en       (sample_en),
        .dout            (dif),
        .overflow        (overflow),
        .drop_count      (drop_count),
        .clear_ovf       (clear_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: m_q doubles as the expected FIFO and the output scoreboard.
    int m_q[$];
    int m_phase = 0;
    int m_ovf   = 0;
    int m_drop  = 0;
    bit cmp_on  = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare DUT outputs with the reference, cross the edge, advance the reference.
    task automatic step();
        bit full;
        bit pop;
        bit keep;
        int r;
        if (cmp_on) begin
            chk("valid", int'(dif.out_valid), (m_q.size() != 0) ? 1 : 0);
            chk("ovf",   int'(overflow),      m_ovf);
            chk("drops", int'(drop_count),    m_drop);
            if (m_q.size() == 0) chk("idle_dat", int'(dif.out_data), 0);
        end
        full = (m_q.size() == DEPTH);
        pop  = !reset && (m_q.size() != 0) && dif.out_ready;
        keep = !reset && sample_en && (m_phase == 0);
        r    = (int'(filtered_scaled) + 64) / 128;
        if (pop) begin
            chk("data", int'(dif.out_data), m_q[0]);
            void'(m_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (reset) begin
            m_q.delete();
            m_phase = 0;
            m_ovf   = 0;
            m_drop  = 0;
        end else begin
            if (keep && (!full || pop)) begin
                m_q.push_back(r);
            end else if (keep) begin
                m_ovf  = 1;
                m_drop = clear_ovf ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            end else if (clear_ovf) begin
                m_ovf  = 0;
                m_drop = 0;
            end
            if (sample_en) m_phase = (m_phase == DECIM - 1) ? 0 : m_phase + 1;
        end
    endtask

    task automatic cyc(input bit en, input int val, input bit rdy, input bit clr);
        sample_en       = en;
        filtered_scaled = val[N-1:0];
        dif.out_ready   = rdy;
        clear_ovf       = clr;
        step();
    endtask

    // One kept sample followed by DECIM-1 discarded ones.
    task automatic kept_sample(input int val, input bit rdy_keep, input bit rdy_rest, input bit clr);
        cyc(1'b1, val, rdy_keep, clr);
        for (int i = 1; i < DECIM; i++) cyc(1'b1, 0, rdy_rest, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, rdy, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        reset  = 1'b0;
        cmp_on = 1'b1;
        chk("rst_valid", int'(dif.out_valid), 0);
        chk("rst_data",  int'(dif.out_data),  0);

        // Mid-stream reset with three entries buffered.
        for (int i = 0; i < 12; i++) cyc(1'b1, 128 * (i + 1), 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 128 * 20, 1'b0, 1'b0);
        reset = 1'b0;
        chk("mrst_valid", int'(dif.out_valid), 0);
        chk("mrst_drops", int'(drop_count),    0);
        chk("mrst_ovf",   int'(overflow),      0);
        cyc(1'b1, 128 * 7, 1'b1, 1'b0);
        chk("mrst_first", int'(dif.out_data), 7);
        for (int i = 1; i < DECIM; i++) cyc(1'b1, 0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Continuous stream, decimate by 4, outputs k = 0,4,8,12.
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 128 * k, 1'b1, 1'b0);
            if (k % DECIM == 0) begin
                chk("stream_vld", int'(dif.out_valid), 1);
                chk("stream_dat", int'(dif.out_data),  k);
            end
        end
        idle(3, 1'b1);

        // Rounding boundaries.
        kept_sample(191, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        kept_sample(192, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        kept_sample(65535, 1'b0, 1'b0, 1'b0);
        chk("rnd_65535", int'(dif.out_data), 512);
        idle(3, 1'b1);
        cyc(1'b1, 191, 1'b0, 1'b0);
        chk("rnd_191", int'(dif.out_data), 1);
        for (int i = 1; i < DECIM; i++) cyc(1'b1, 0, 1'b1, 1'b0);
        cyc(1'b1, 192, 1'b0, 1'b0);
        chk("rnd_192", int'(dif.out_data), 2);
        for (int i = 1; i < DECIM; i++) cyc(1'b1, 0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Stall: six kept samples into a four-deep FIFO, then drain.
        for (int i = 0; i < 6; i++) kept_sample(128 * (100 + i), 1'b0, 1'b0, 1'b0);
        chk("stall_ovf",   int'(overflow),   1);
        chk("stall_drops", int'(drop_count), 2);
        idle(6, 1'b1);
        chk("drain_empty", int'(dif.out_valid), 0);

        // Clear alone.
        cyc(1'b0, 0, 1'b1, 1'b1);
        chk("clr_ovf",   int'(overflow),   0);
        chk("clr_drops", int'(drop_count), 0);

        // Full FIFO with keep and pop on the same edge: no drop, new sample is the tail.
        for (int i = 0; i < DEPTH; i++) kept_sample(128 * (10 + i), 1'b0, 1'b0, 1'b0);
        kept_sample(128 * 14, 1'b1, 1'b0, 1'b0);
        chk("full_pp_ovf",   int'(overflow),   0);
        chk("full_pp_drops", int'(drop_count), 0);
        chk("full_pp_head",  int'(dif.out_data), 11);
        idle(6, 1'b1);

        // Drop and clear on the same edge, then clear alone, then saturation.
        for (int i = 0; i < DEPTH; i++) kept_sample(128 * (20 + i), 1'b0, 1'b0, 1'b0);
        kept_sample(128 * 30, 1'b0, 1'b0, 1'b1);
        chk("dropclr_ovf",   int'(overflow),   1);
        chk("dropclr_drops", int'(drop_count), 1);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("clr2_ovf",   int'(overflow),   0);
        chk("clr2_drops", int'(drop_count), 0);
        for (int i = 0; i < 300; i++) kept_sample(128 * 40, 1'b0, 1'b0, 1'b0);
        chk("sat_drops", int'(drop_count), 255);
        chk("sat_ovf",   int'(overflow),   1);
        idle(8, 1'b1);
        chk("end_empty", int'(dif.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
